// File: rtl/vcfg_unit.sv
// vcfg_unit: vector front-end configuration stage.
// Executes vsetvli/vsetivli/vsetvl locally (architectural vtype/vl) and
// forwards every other vector instruction to the dispatcher tagged with the
// vtype/vl in force at acceptance. Strictly one instruction in flight.

package vcfg_unit_pkg;

   // Decoded RVV instruction word layout
   typedef struct packed {
      logic [6:0] func7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] func3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rvv_instruction_t;

   localparam logic [6:0] OPC_V        = 7'b1010111;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [2:0] OPCFG        = 3'b111;
   localparam logic [6:0] F7_VSETVL    = 7'b1000000;

   localparam logic [2:0] EW64      = 3'b011;
   localparam logic [2:0] LMUL_RSVD = 3'b100;
   localparam logic [2:0] LMUL_1_8  = 3'b101;
   localparam logic [2:0] LMUL_1_4  = 3'b110;
   localparam logic [2:0] LMUL_1_2  = 3'b111;

   localparam logic [8:0] VTYPE_ILL = 9'h100;

   // One-hot so each handshake output is a flop bit directly
   localparam int unsigned ST_IDLE_BIT = 0;
   localparam int unsigned ST_RESP_BIT = 1;
   localparam int unsigned ST_FWD_BIT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RESP = 3'b010,
      ST_FWD  = 3'b100
   } state_e;

endpackage

module vcfg_unit
   import vcfg_unit_pkg::*;
#(
   parameter int unsigned VLEN    = 4096,
   parameter int unsigned ELEN    = 64,
   parameter int unsigned VlWidth = $clog2(VLEN) + 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               insn_valid_i,
   output logic               insn_ready_o,
   input  logic [31:0]        insn_i,
   input  logic [63:0]        rs1_i,
   input  logic [63:0]        rs2_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [63:0]        resp_result_o,
   output logic               resp_exception_o,
   output logic               vinsn_valid_o,
   input  logic               vinsn_ready_i,
   output logic [31:0]        vinsn_o,
   output logic [8:0]         vinsn_vtype_o,
   output logic [VlWidth-1:0] vinsn_vl_o,
   output logic [8:0]         vtype_o,
   output logic [VlWidth-1:0] vl_o
);

   localparam int unsigned SewBitsW = 11;

   state_e state_q, state_d;

   logic [8:0]         vtype_q, vtype_d;
   logic [VlWidth-1:0] vl_q, vl_d;
   logic [63:0]        result_q, result_d;
   logic               exc_q, exc_d;
   logic [31:0]        vinsn_q, vinsn_d;
   logic [8:0]         vinsn_vtype_q, vinsn_vtype_d;
   logic [VlWidth-1:0] vinsn_vl_q, vinsn_vl_d;

   rvv_instruction_t   insn;
   logic               accept;
   logic               is_cfg_opc;
   logic               is_vsetvli;
   logic               is_vsetivli;
   logic               is_vsetvl;
   logic               cfg_sel;
   logic               is_vec;
   logic               fwd_sel;
   logic [63:0]        vtypei;
   logic [2:0]         vlmul;
   logic [2:0]         vsew;
   logic [1:0]         frac_shift;
   logic [SewBitsW-1:0] sew_bits;
   logic [SewBitsW-1:0] elen_frac;
   logic               vill;
   logic [3:0]         sew_shift;
   logic [VlWidth-1:0] vlmax_base;
   logic [VlWidth-1:0] vlmax;
   logic [63:0]        avl;
   logic [VlWidth-1:0] vl_calc;
   logic [8:0]         new_vtype;
   logic [VlWidth-1:0] new_vl;

   // Instruction classification and vtype/vl computation for the offered word
   always_comb begin
      insn        = rvv_instruction_t'(insn_i);
      accept      = (state_q == ST_IDLE) && insn_valid_i;

      is_cfg_opc  = (insn.opcode == OPC_V) && (insn.func3 == OPCFG);
      is_vsetvli  = ~insn.func7[6];
      is_vsetivli = (insn.func7[6:5] == 2'b11);
      is_vsetvl   = (insn.func7 == F7_VSETVL);
      cfg_sel     = is_cfg_opc && (is_vsetvli || is_vsetivli || is_vsetvl);

      is_vec = ((insn.opcode == OPC_V) && (insn.func3 != OPCFG)) ||
               (((insn.opcode == OPC_LOAD_FP) || (insn.opcode == OPC_STORE_FP)) &&
                ((insn.func3 == 3'b000) || (insn.func3 == 3'b101) ||
                 (insn.func3 == 3'b110) || (insn.func3 == 3'b111)));
      // A vector instruction under an illegal vtype is answered with an exception
      fwd_sel = is_vec && ~vtype_q[8];

      if (is_vsetvli) begin
         vtypei = 64'({insn.func7[5:0], insn.rs2});
      end else if (is_vsetivli) begin
         vtypei = 64'({insn.func7[4:0], insn.rs2});
      end else begin
         vtypei = rs2_i;
      end

      vlmul = vtypei[2:0];
      vsew  = vtypei[5:3];

      unique case (vlmul)
         LMUL_1_8: frac_shift = 2'd3;
         LMUL_1_4: frac_shift = 2'd2;
         LMUL_1_2: frac_shift = 2'd1;
         default:  frac_shift = 2'd0;
      endcase

      // Fractional LMUL legality: SEW <= ELEN * LMUL
      sew_bits  = SewBitsW'(8) << vsew;
      elen_frac = SewBitsW'(ELEN) >> frac_shift;

      vill = (|vtypei[63:8]) ||
             (vsew > EW64) ||
             (vlmul == LMUL_RSVD) ||
             (vlmul[2] && (sew_bits > elen_frac));

      sew_shift  = 4'(vsew) + 4'd3;
      vlmax_base = VlWidth'(VLEN) >> sew_shift;
      if (vlmul[2]) begin
         vlmax = vlmax_base >> frac_shift;
      end else begin
         vlmax = vlmax_base << vlmul[1:0];
      end

      // Application vector length selection
      if (is_vsetivli) begin
         avl = 64'(insn.rs1);
      end else if (insn.rs1 != 5'd0) begin
         avl = rs1_i;
      end else if (insn.rd != 5'd0) begin
         avl = 64'(vlmax);
      end else begin
         avl = 64'(vl_q);
      end

      vl_calc = (avl < 64'(vlmax)) ? VlWidth'(avl) : vlmax;

      if (vill) begin
         new_vtype = VTYPE_ILL;
         new_vl    = '0;
      end else begin
         new_vtype = {1'b0, vtypei[7:6], vsew, vlmul};
         new_vl    = vl_calc;
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: one instruction in flight, released by its output handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (insn_valid_i) begin
               state_d = fwd_sel && !cfg_sel ? ST_FWD : ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_FWD: begin
            if (vinsn_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: next values of CSRs and payload registers, loaded only on acceptance
   always_comb begin
      vtype_d       = vtype_q;
      vl_d          = vl_q;
      result_d      = result_q;
      exc_d         = exc_q;
      vinsn_d       = vinsn_q;
      vinsn_vtype_d = vinsn_vtype_q;
      vinsn_vl_d    = vinsn_vl_q;

      if (accept) begin
         if (cfg_sel) begin
            vtype_d  = new_vtype;
            vl_d     = new_vl;
            result_d = 64'(new_vl);
            exc_d    = 1'b0;
         end else if (fwd_sel) begin
            vinsn_d       = insn_i;
            vinsn_vtype_d = vtype_q;
            vinsn_vl_d    = vl_q;
         end else begin
            result_d = '0;
            exc_d    = 1'b1;
         end
      end
   end

   // CSR and payload registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vtype_q       <= VTYPE_ILL;
         vl_q          <= '0;
         result_q      <= '0;
         exc_q         <= 1'b0;
         vinsn_q       <= '0;
         vinsn_vtype_q <= '0;
         vinsn_vl_q    <= '0;
      end else begin
         vtype_q       <= vtype_d;
         vl_q          <= vl_d;
         result_q      <= result_d;
         exc_q         <= exc_d;
         vinsn_q       <= vinsn_d;
         vinsn_vtype_q <= vinsn_vtype_d;
         vinsn_vl_q    <= vinsn_vl_d;
      end
   end

   assign insn_ready_o     = state_q[ST_IDLE_BIT];
   assign resp_valid_o     = state_q[ST_RESP_BIT];
   assign vinsn_valid_o    = state_q[ST_FWD_BIT];
   assign resp_result_o    = result_q;
   assign resp_exception_o = exc_q;
   assign vinsn_o          = vinsn_q;
   assign vinsn_vtype_o    = vinsn_vtype_q;
   assign vinsn_vl_o       = vinsn_vl_q;
   assign vtype_o          = vtype_q;
   assign vl_o             = vl_q;

endmodule
